counter_ctrl: RTL and testbench

//  Upstream sequencer for the WIDTH-bit load/enable counter. It accepts a start/limit/mode command over
//  a valid/ready handshake and drives the counter's load, enab and cnt_in. It monitors the counter's
//  cnt_out and pulses done when the limit is reached. One-shot and periodic (auto-reload) modes.

---
 rtl/counter_pkg.sv | 13 +
 rtl/counter_ctrl.sv | 89 ++++++++
 tb/tb_counter_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the load/enable counter and its upstream sequencer.
package counter_pkg;

  localparam int CNT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_ctrl.sv
// Sequencer for an external load/enable counter: takes start/limit/mode commands,
// drives load/enab/cnt_in and pulses done when cnt_out reaches the limit.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready.
  // cmd_ready is high only in IDLE; cmd_valid offered in any other state is ignored.
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_mode,
  input  logic             stop,
  input  logic [WIDTH-1:0] cnt_out,
  output logic             load,
  output logic             enab,
  output logic [WIDTH-1:0] cnt_in,
  output logic             done,
  output logic             busy,
  output state_t           dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_limit;
  logic             r_mode;
  logic             r_done;
  logic             w_accept;
  logic             w_at_limit;

  assign w_accept   = cmd_valid && (r_state == ST_IDLE);
  assign w_at_limit = (cnt_out == r_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_start <= '0;
      r_limit <= '0;
      r_mode  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == ST_DONE);
      if (w_accept) begin
        r_start <= cmd_start;
        r_limit <= cmd_limit;
        r_mode  <= cmd_mode;
      end
    end
  end

  // enab is decoded from the live cnt_out so the counter stops exactly on the limit.
  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    load      = 1'b0;
    enab      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = ST_LOAD;
      end
      ST_LOAD: begin
        load   = 1'b1;
        w_next = stop ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        enab = !w_at_limit && !stop;
        if (stop)            w_next = ST_IDLE;
        else if (w_at_limit) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = (r_mode && !stop) ? ST_LOAD : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign done      = r_done;
  assign busy      = (r_state != ST_IDLE);
  assign cnt_in    = r_start;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl driving a behavioural load/enable counter; expectations come
// from the command timeline arithmetic (d = limit - start mod 32, period d + 3).
module tb_counter_ctrl;
  import counter_pkg::*;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_limit = '0;
  logic         cmd_mode = 1'b0;
  logic         stop = 1'b0;
  logic [W-1:0] cnt_out;
  logic         load;
  logic         enab;
  logic [W-1:0] cnt_in;
  logic         done;
  logic         busy;
  state_t       dbg_state;

  int           n_pass = 0;
  int           n_total = 0;
  logic [W-1:0] exp_cnt = '0;
  logic [W-1:0] exp_cin = '0;

  always #5 clk = ~clk;

  counter_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_limit(cmd_limit), .cmd_mode(cmd_mode),
    .stop(stop), .cnt_out(cnt_out), .load(load), .enab(enab), .cnt_in(cnt_in),
    .done(done), .busy(busy), .dbg_state(dbg_state)
  );

  // External counter: load has priority over enab, reset shared with the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt_out <= '0;
    else if (load) cnt_out <= cnt_in;
    else if (enab) cnt_out <= cnt_out + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic e_ready, input logic e_busy,
                         input logic e_load, input logic e_enab, input logic e_done,
                         input logic [W-1:0] e_cnt, input logic [W-1:0] e_cin);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(e_ready));
    chk({tag, ".busy"},      32'(busy),      32'(e_busy));
    chk({tag, ".load"},      32'(load),      32'(e_load));
    chk({tag, ".enab"},      32'(enab),      32'(e_enab));
    chk({tag, ".done"},      32'(done),      32'(e_done));
    chk({tag, ".cnt_out"},   32'(cnt_out),   32'(e_cnt));
    chk({tag, ".cnt_in"},    32'(cnt_in),    32'(e_cin));
  endtask

  // One command from accept (k=0) for `cycles` further cycles; stop_k/bogus_k < 0 disables.
  task automatic run_cmd(input string tag, input logic [W-1:0] s, input logic [W-1:0] l,
                         input logic m, input int cycles, input int stop_k, input int bogus_k);
    logic [W-1:0] diff;
    int           d, p, j;
    logic         stopped, act, e_load, e_enab, e_done;
    logic [W-1:0] e_cnt;
    diff = l - s;
    d = int'(diff);
    p = d + 3;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_start = s; cmd_limit = l; cmd_mode = m; stop = 1'b0;
    @(negedge clk);
    chk_all({tag, ".accept"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_cnt, exp_cin);
    exp_cin = s;
    stopped = 1'b0;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk); #1;
      cmd_valid = (k == bogus_k);
      cmd_start = (k == bogus_k) ? ~s : s;
      cmd_limit = (k == bogus_k) ? l + 5'd7 : l;
      cmd_mode  = (k == bogus_k) ? ~m : m;
      stop      = (k == stop_k);
      j   = m ? (k - 1) % p : k - 1;
      act = !stopped && (m || (k - 1 < p));
      if (!act) begin
        e_load = 1'b0; e_enab = 1'b0; e_done = 1'b0; e_cnt = exp_cnt;
      end else begin
        e_load = (j == 0);
        e_enab = (j >= 1) && (j <= d) && !stop;
        e_done = (j == d + 2);
        e_cnt  = (j == 0) ? exp_cnt : W'(int'(s) + ((j - 1 < d) ? j - 1 : d));
      end
      @(negedge clk);
      chk_all($sformatf("%s.k%0d", tag, k), !act, act, e_load, e_enab, e_done, e_cnt, exp_cin);
      exp_cnt = e_load ? s : (e_enab ? e_cnt + 1'b1 : e_cnt);
      if (act && stop) stopped = 1'b1;
    end
    cmd_valid = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rs, rl, rdiff;
    logic         rm;
    int           rp, rcyc, rstop, rbog;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00);
    chk("reset.state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed scenarios
    run_cmd("oneshot", 5'h15, 5'h18, 1'b0, 8, -1, -1);
    run_cmd("wrap",    5'h1E, 5'h01, 1'b0, 8, -1, -1);
    run_cmd("equal",   5'h0A, 5'h0A, 1'b0, 5, -1, -1);
    run_cmd("periodic", 5'h00, 5'h02, 1'b1, 19, 17, -1);
    run_cmd("busycmd", 5'h04, 5'h09, 1'b0, 10, -1, 3);
    run_cmd("stopload", 5'h07, 5'h0C, 1'b0, 4, 1, -1);
    run_cmd("stopdone", 5'h10, 5'h11, 1'b1, 7, 4, 2);

    // Randomised commands
    for (int r = 0; r < 10; r++) begin
      rs = W'($urandom_range(0, 31));
      rl = W'($urandom_range(0, 31));
      rm = 1'($urandom_range(0, 1));
      rdiff = rl - rs;
      rp = int'(rdiff) + 3;
      if (rm) begin
        rcyc  = 2 * rp + int'($urandom_range(0, rp));
        rstop = int'($urandom_range(2, rcyc - 1));
      end else begin
        rcyc  = rp + 2;
        rstop = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, rp)) : -1;
      end
      rbog = int'($urandom_range(1, (rstop > 0) ? rstop : rp));
      run_cmd($sformatf("rand%0d", r), rs, rl, rm, rcyc, rstop, rbog);
    end

    // Asynchronous reset in the middle of a run
    run_cmd("prerst", 5'h03, 5'h14, 1'b0, 4, -1, -1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00);
    @(negedge clk);
    chk_all("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 5'h00);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    exp_cin = '0;
    run_cmd("recover", 5'h02, 5'h04, 1'b0, 7, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
